// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited requests to
// instruction memory and buffers returned words with their PCs for decode.
module fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0040_0000),
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic              imem_gnt_in,
  input  logic              imem_rvalid_in,
  input  logic [DATA_W-1:0] imem_rdata_in,
  input  logic              redirect_in,
  input  logic [ADDR_W-1:0] redirect_pc_in,
  output logic              inst_valid_out,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  input  logic              inst_ready_in,
  output logic              err_out
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic [CW:0]       credit_used;
  logic [ADDR_W-1:0] target_pc;
  logic              unused_lsbs;

  assign target_pc   = {redirect_pc_in[ADDR_W-1:2], 2'b00};
  assign unused_lsbs = ^redirect_pc_in[1:0];

  // Credits count both in-flight and buffered words, so a full FIFO can never overflow.
  assign credit_used    = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_out   = !reset && !redirect_in && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_out  = fetch_pc_q;
  assign issue          = imem_req_out & imem_gnt_in;

  assign inst_valid_out = (count_q != '0);
  assign inst_out       = inst_valid_out ? data_mem_q[rd_ptr_q] : '0;
  assign inst_pc_out    = inst_valid_out ? pc_mem_q[rd_ptr_q] : '0;
  assign pop            = inst_valid_out & inst_ready_in & !redirect_in;
  assign err_out        = err_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    err_d      = err_q;
    push       = 1'b0;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      outst_d    = outst_q + CW'(1);
    end

    if (imem_rvalid_in) begin
      if (outst_q == '0) begin
        err_d = 1'b1;
      end else begin
        outst_d = outst_d - CW'(1);
        if (!redirect_in) begin
          if (disc_q != '0) begin
            disc_d = disc_q - CW'(1);
          end else begin
            push = 1'b1;
          end
        end
      end
    end

    if (push) begin
      resp_pc_d = resp_pc_q + ADDR_W'(4);
      wr_ptr_d  = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // Every word still in flight after this cycle's accounting belongs to the old stream.
    if (redirect_in) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      disc_d     = outst_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      data_mem_q[wr_ptr_q] <= imem_rdata_in;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the free-running PC/add-4 loop of the single-cycle core.
- Owns the fetch PC, issues pipelined requests to instruction memory over a request/grant/valid handshake, and buffers returned words with their PCs in a FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Accepts taken-branch/jump redirects that flush in-flight and buffered work.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width.
- RESET_PC, 32'h00400000, first address fetched after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2. Also the cap on in-flight plus buffered words.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- imem_req_out  output  1  fetch request valid.
- imem_addr_out  output  ADDR_W  fetch address; word-aligned, bits [1:0] always 0.
- imem_gnt_in  input  1  memory accepts request this cycle (req & gnt = issue).
- imem_rvalid_in  input  1  response word valid; responses return in issue order, at least 1 cycle after issue.
- imem_rdata_in  input  DATA_W  response word.
- redirect_in  input  1  taken branch/jump from execute.
- redirect_pc_in  input  ADDR_W  redirect target.
- inst_valid_out  output  1  FIFO head valid.
- inst_out  output  DATA_W  head instruction; 0 when not valid.
- inst_pc_out  output  ADDR_W  head PC; 0 when not valid.
- inst_ready_in  input  1  decode consumes head when valid & ready.
- err_out  output  1  sticky protocol error flag.

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, err_out=0. All outputs 0 except imem_addr_out, which equals RESET_PC. Reset mid-operation drops everything; responses arriving after reset for pre-reset requests are not tracked and raise err_out.
- Credit rule: imem_req_out = !reset & !redirect_in & (outstanding + fifo_count < FIFO_DEPTH). A consumed head in the same cycle does not add credit until the next cycle.
- imem_addr_out = fetch_pc, combinational from a register.
- Issue (req & gnt): fetch_pc += 4 mod 2^ADDR_W, so 0xFFFFFFFC wraps to 0. outstanding += 1.
- Response with discard>0: word dropped, discard -= 1, outstanding -= 1.
- Response with discard=0: {resp_pc, rdata} pushed into the FIFO, resp_pc += 4 mod 2^ADDR_W, outstanding -= 1. The word is visible on inst_* the next cycle (issue-to-decode latency is memory latency + 1).
- Response with outstanding=0: word ignored, err_out set until reset.
- Pop: on inst_valid_out & inst_ready_in, head advances. Push and pop in the same cycle are both honoured. A full FIFO never overflows because of the credit rule.
- Redirect (highest priority, any cycle):
  - FIFO flushed, so inst_valid_out=0 next cycle; a same-cycle pop is irrelevant.
  - fetch_pc and resp_pc = {redirect_pc_in[ADDR_W-1:2], 2'b00}, so misaligned targets are truncated.
  - discard = outstanding after this cycle's issue/response accounting; no issue occurs this cycle.
  - A response arriving in the redirect cycle itself is dropped.
- Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Counter widths: outstanding and discard are clog2(FIFO_DEPTH)+1 bits. Neither underflows; underflow would be a protocol error and sets err_out.

Test Plan:
- Reset release, gnt=1, 1-cycle latency, ready=1 -> requests to 0x00400000, 0x00400004, …; inst_pc_out sequence matches, inst_out equals returned data; first inst_valid_out 2 cycles after first issue.
- ready=0, gnt=1, latency 1 -> exactly 4 issues, then imem_req_out=0; FIFO full with 4 entries. Ready=1 for one cycle -> one pop and one new issue the following cycle.
- Two requests in flight, redirect_in=1 with redirect_pc_in=0x00400100 -> both late responses dropped, next inst_pc_out=0x00400100, no stale word ever valid.
- redirect_pc_in=0x00400106 -> imem_addr_out=0x00400104.
- Force fetch_pc to 0xFFFFFFF8 via redirect, stream 3 words -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rvalid with nothing outstanding -> err_out=1 and stays 1; reset asserted mid-stream with 2 outstanding -> outputs cleared next cycle, next request addr 0x00400000.
